mode3_exp_ctrl: RTL

Sequencer that streams a vector of `DATAWIDTH floating-point elements from the softmax local buffer through the two-lane mode3 exponent datapath and writes the results back. Each buffer word packs two elements (lane 0 in the low half), so one pair is issued per cycle. Provides the start/busy/done control, pipeline enable, valid/address alignment across the datapath latency, and downstream back-pressure.

---
 rtl/mode3_exp_ctrl_pkg.sv | 23 ++
 rtl/mode3_exp_align.sv | 44 ++++
 rtl/mode3_exp_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mode3_exp_ctrl_pkg.sv
// Shared types and widths for the mode3 exponent sequencer.
// DATAWIDTH falls back to 16 bits when the build does not define it.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

package mode3_exp_ctrl_pkg;

    localparam int DW     = `DATAWIDTH;
    localparam int LANES  = 2;
    localparam int PAIR_W = LANES * DW;

    localparam logic [1:0] MASK_BOTH = 2'b11;
    localparam logic [1:0] MASK_LO   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

endpackage

// File: rtl/mode3_exp_align.sv
// Valid/address/mask shift register that follows each pair through
// the datapath; every stage holds while en is low.
module mode3_exp_align
    import mode3_exp_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_mask,
    output logic [DEPTH-1:0]  valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_mask
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [1:0]        mask_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else if (en) begin
            valid     <= {valid[DEPTH-2:0], in_valid};
            addr_q[0] <= in_addr;
            mask_q[0] <= in_mask;
            for (int i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
                mask_q[i] <= mask_q[i-1];
            end
        end
    end

    assign out_addr = addr_q[DEPTH-1];
    assign out_mask = mask_q[DEPTH-1];

endmodule

// File: rtl/mode3_exp_ctrl.sv
// Streams element pairs from the softmax buffer through the mode3 exp lanes.
// Define MODE3_EXP_CTRL_PERF_EN to add busy/stall cycle counters.
module mode3_exp_ctrl
    import mode3_exp_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 9,
    parameter int EXP_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PAIR_W-1:0] rd_data,
    output logic [DW-1:0]     exp_inp0,
    output logic [DW-1:0]     exp_inp1,
    output logic              exp_en,
    input  logic [DW-1:0]     exp_outp0,
    input  logic [DW-1:0]     exp_outp1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PAIR_W-1:0] wr_data,
    output logic [1:0]        wr_mask,
    input  logic              stall
`ifdef MODE3_EXP_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int DEPTH = EXP_LAT + 2;

    state_t            state, state_n;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  pairs_q, cnt_q;
    logic              odd_q;
    logic              pend_v;
    logic [ADDR_W-1:0] pend_addr;
    logic [1:0]        pend_mask;
    logic [DEPTH-1:0]  vld;
    logic [LEN_W:0]    len_p1;
    logic              accept, adv, last_issue;
    logic              inflight, drain_done;

    assign len_p1     = {1'b0, len} + (LEN_W+1)'(1);
    assign accept     = (state == S_IDLE) && start;
    assign adv        = !stall;
    assign rd_en      = (state == S_ISSUE) && adv;
    assign rd_addr    = rd_en ? src_q + ADDR_W'(cnt_q) : '0;
    assign last_issue = rd_en && (cnt_q == pairs_q - LEN_W'(1));
    assign inflight   = pend_v || (|vld);
    assign exp_en     = adv && inflight;
    assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
    assign done       = (state == S_FIN);
    assign wr_en      = vld[DEPTH-1];

    // Leave DRAIN in the same cycle the final write is accepted.
    assign drain_done = !pend_v && !(|vld[DEPTH-2:0])
                        && !(wr_en && stall);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Zero-length jobs pass through an empty DRAIN so busy shows for a cycle.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = (len == '0) ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (last_issue) state_n = S_DRAIN;
            S_DRAIN: if (drain_done) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            pairs_q <= '0;
            odd_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            pairs_q <= len_p1[LEN_W:1];
            odd_q   <= len[0];
            cnt_q   <= '0;
        end else if (rd_en) begin
            cnt_q   <= cnt_q + LEN_W'(1);
        end
    end

    // Read in flight: rd_data is not valid until the cycle after rd_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_mask <= '0;
        end else if (adv) begin
            pend_v    <= rd_en;
            pend_addr <= rd_en ? dst_q + ADDR_W'(cnt_q) : '0;
            pend_mask <= !rd_en ? 2'b00 :
                         (last_issue && odd_q) ? MASK_LO : MASK_BOTH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_inp0 <= '0;
            exp_inp1 <= '0;
        end else if (adv && pend_v) begin
            exp_inp0 <= rd_data[DW-1:0];
            exp_inp1 <= rd_data[PAIR_W-1:DW];
        end
    end

    mode3_exp_align #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_align (
        .clk      (clk),
        .reset    (reset),
        .en       (adv),
        .in_valid (pend_v),
        .in_addr  (pend_addr),
        .in_mask  (pend_mask),
        .valid    (vld),
        .out_addr (wr_addr),
        .out_mask (wr_mask)
    );

    always_ff @(posedge clk) begin
        if (reset)    wr_data <= '0;
        else if (adv) wr_data <= vld[EXP_LAT] ? {exp_outp1, exp_outp0} : '0;
    end

`ifdef MODE3_EXP_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (busy && stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
